nesctrl_resp: RTL and testbench



---
 rtl/nesctrl_pkg.sv | 21 ++
 rtl/nesctrl_sync_edge.sv | 32 +++
 rtl/nesctrl_resp.sv | 81 ++++++++
 tb/tb_nesctrl_resp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nesctrl_pkg.sv
// Shared constants for the NES controller link: button indices and
// shift-count width helper.
package nesctrl_pkg;

    localparam int NESCTRL_BTN_W = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nesctrl_sync_edge.sv
// Synchroniser for one asynchronous line plus a registered stage for
// rise/fall detection on the synchronised level.
module nesctrl_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Reset parks the line at idle low so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync[SYNC_STAGES-1];
    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/nesctrl_resp.sv
// Device-side NES controller emulation: latches a button vector on PL and
// shifts it out LSB-first on Q7 for each rising shift clock.
module nesctrl_resp
    import nesctrl_pkg::*;
#(
    parameter int BTN_W       = NESCTRL_BTN_W,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BTN_W-1:0]         buttons,
    input  logic                     pl,
    input  logic                     nclk,
    output logic                     q7,
    output logic [BTN_W-1:0]         latched,
    output logic                     read_done,
    output logic                     overshift,
    output logic [cnt_w(BTN_W)-1:0]  shift_cnt
);

    localparam int CW = cnt_w(BTN_W);

    logic             pl_s, pl_rise, pl_fall;
    logic             nclk_s, nclk_rise, nclk_fall;
    logic [BTN_W-1:0] sr;
    logic             unused_edges;

    nesctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pl),
        .lvl  (pl_s),
        .rise (pl_rise),
        .fall (pl_fall)
    );

    nesctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (nclk),
        .lvl  (nclk_s),
        .rise (nclk_rise),
        .fall (nclk_fall)
    );

    assign unused_edges = ^{pl_rise, nclk_s, nclk_fall};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr        <= {BTN_W{FILL_BIT}};
            q7        <= FILL_BIT;
            latched   <= '0;
            read_done <= 1'b0;
            overshift <= 1'b0;
            shift_cnt <= '0;
        end else begin
            read_done <= 1'b0;
            q7        <= sr[0];
            // sr still holds the last load here: pl_s was high one cycle ago.
            if (pl_fall)
                latched <= ACTIVE_LOW ? ~sr : sr;
            if (pl_s) begin
                sr        <= ACTIVE_LOW ? ~buttons : buttons;
                shift_cnt <= '0;
                overshift <= 1'b0;
            end else if (nclk_rise) begin
                sr <= {FILL_BIT, sr[BTN_W-1:1]};
                if (shift_cnt == CW'(BTN_W)) begin
                    overshift <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CW'(BTN_W - 1))
                        read_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nesctrl_resp.sv
// Directed + randomized bench for nesctrl_resp with a bench-side reader
// and a per-bit model of what the controller should present.
module tb_nesctrl_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] buttons = '0;
    logic       pl = 1'b0;
    logic       nclk = 1'b0;
    logic       q7;
    logic [7:0] latched;
    logic       read_done;
    logic       overshift;
    logic [3:0] shift_cnt;

    int tot_n  = 0;
    int pass_n = 0;
    int rd_cnt = 0;

    nesctrl_resp dut (
        .clk       (clk),
        .rst       (rst),
        .buttons   (buttons),
        .pl        (pl),
        .nclk      (nclk),
        .q7        (q7),
        .latched   (latched),
        .read_done (read_done),
        .overshift (overshift),
        .shift_cnt (shift_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (read_done === 1'b1) rd_cnt <= rd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reader model: what a NES controller shows for bit k of a read.
    function automatic logic exp_q7(input logic [7:0] btn, input int k);
        if (k < 8) return ~btn[k];
        return 1'b1;
    endfunction

    function automatic int exp_cnt(input int k);
        return (k > 8) ? 8 : k;
    endfunction

    task automatic do_load(input logic [7:0] btn, input int hold);
        buttons = btn;
        pl = 1'b1;
        cyc(hold);
        pl = 1'b0;
        cyc(6);
    endtask

    task automatic pulse(input int ph);
        nclk = 1'b1;
        cyc(ph);
        nclk = 1'b0;
        cyc(ph);
    endtask

    // Full poll as the system reader does it; returns pressed=1 vector.
    task automatic poll(input logic [7:0] btn, output logic [7:0] data);
        do_load(btn, 10);
        for (int k = 0; k < 8; k++) begin
            data[k] = ~q7;
            pulse(8);
        end
    endtask

    initial begin
        logic [7:0] btn, rd;
        int         nsh, rd0, ph;

        // Reset
        rst = 1'b0;
        cyc(3);
        chk("rst_q7", q7, 1);
        chk("rst_latched", latched, 0);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_done", read_done, 0);
        chk("rst_over", overshift, 0);
        rst = 1'b1;
        cyc(2);

        // Full read of A+Start
        rd0 = rd_cnt;
        do_load(8'h09, 10);
        chk("full_latched", latched, 8'h09);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_q7_%0d", k), q7, exp_q7(8'h09, k));
            pulse(8);
        end
        chk("full_q7_fill", q7, 1);
        chk("full_cnt", shift_cnt, 8);
        chk("full_done_once", rd_cnt - rd0, 1);
        chk("full_over", overshift, 0);

        // Over-read
        pulse(8);
        chk("over_q7", q7, 1);
        chk("over_flag", overshift, 1);
        chk("over_cnt", shift_cnt, 8);
        chk("over_no_done", rd_cnt - rd0, 1);
        buttons = 8'h00;
        pl = 1'b1;
        cyc(6);
        chk("over_cleared", overshift, 0);
        chk("load_cnt_zero", shift_cnt, 0);
        pl = 1'b0;
        cyc(6);

        // Load wins over a simultaneous shift clock
        buttons = 8'h01;
        pl = 1'b1;
        cyc(3);
        nclk = 1'b1;
        cyc(4);
        nclk = 1'b0;
        cyc(6);
        pl = 1'b0;
        cyc(8);
        chk("prio_q7", q7, 0);
        chk("prio_cnt", shift_cnt, 0);
        chk("prio_latched", latched, 8'h01);

        // Reset mid-read
        do_load(8'hFF, 10);
        for (int k = 0; k < 3; k++) pulse(8);
        chk("mid_cnt_pre", shift_cnt, 3);
        rst = 1'b0;
        cyc(1);
        chk("mid_q7", q7, 1);
        chk("mid_cnt", shift_cnt, 0);
        chk("mid_latched", latched, 0);
        rst = 1'b1;
        cyc(3);
        do_load(8'hFF, 10);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("mid_re_q7_%0d", k), q7, 0);
            pulse(8);
        end

        // Loopback through the bench-side reader
        poll(8'hA5, rd);
        chk("loop_data", rd, 8'hA5);
        chk("loop_latched", latched, 8'hA5);

        // Randomized reads: random vector, shift count and phase width;
        // buttons are scrambled after the latch and must not matter.
        for (int it = 0; it < 20; it++) begin
            btn = 8'($urandom);
            nsh = $urandom_range(0, 10);
            rd0 = rd_cnt;
            do_load(btn, $urandom_range(3, 12));
            buttons = 8'($urandom);
            chk($sformatf("rnd%0d_latched", it), latched, btn);
            for (int k = 0; k < nsh; k++) begin
                chk($sformatf("rnd%0d_q7_%0d", it, k), q7, exp_q7(btn, k));
                ph = $urandom_range(5, 9);
                pulse(ph);
            end
            chk($sformatf("rnd%0d_q7_end", it), q7, exp_q7(btn, nsh));
            chk($sformatf("rnd%0d_cnt", it), shift_cnt, exp_cnt(nsh));
            chk($sformatf("rnd%0d_over", it), overshift, (nsh > 8) ? 1 : 0);
            chk($sformatf("rnd%0d_done", it), rd_cnt - rd0, (nsh >= 8) ? 1 : 0);
            // idle hold: no edges, nothing moves
            cyc(20);
            chk($sformatf("rnd%0d_idle_q7", it), q7, exp_q7(btn, nsh));
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
